skew_delay_array: RTL and testbench
===================================

Name: skew_delay_array

Overview:
- Parametrised multi-lane delay block that feeds a systolic array edge.
- Lane k is delayed by BASE_DEPTH + k*STEP cycles (skew mode) or BASE_DEPTH + (CHANNELS-1-k)*STEP cycles (deskew mode, for draining array outputs).
- Adds a global advance enable (stall), per-lane valid tracking with zero padding, a controlled flush with a drained pulse, and a mode lock while data is in flight.

Parameters:
- WIDTH, 16, data bits per lane.
- CHANNELS, 4, number of lanes (>=1).
- BASE_DEPTH, 0, delay of the shortest lane in cycles (>=0).
- STEP, 1, extra delay per lane position (>=0).
- MAX_DEPTH (localparam) = BASE_DEPTH + (CHANNELS-1)*STEP.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  advance; when 0, every stage, the flush counter and the FSM hold.
- in_valid  in  1  data_in beat valid; sampled only when en=1 and state != FLUSH.
- data_in  in  CHANNELS*WIDTH  lane k = bits [k*WIDTH +: WIDTH].
- deskew  in  1  mode request (0 = skew, 1 = deskew); applied only when unlocked.
- flush  in  1  single-cycle request to drain the pipeline.
- data_out  out  CHANNELS*WIDTH  delayed lanes; a lane is forced to 0 when its valid is low.
- out_valid  out  CHANNELS  per-lane valid.
- busy  out  1  OR of all valid stage bits across all lanes.
- drained  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset (async, reset_n=0): all stage data and valid bits clear to 0, mode_q=0 (skew), FSM=IDLE, flush counter=0. Outputs go to 0 immediately, without a clock edge. Reset mid-operation discards all in-flight beats.
- Lane depth: d_k = BASE_DEPTH + k*STEP when mode_q=0, BASE_DEPTH + (CHANNELS-1-k)*STEP when mode_q=1. Each lane is built MAX_DEPTH deep; a mux selects tap d_k.
- Lane with d_k=0: combinational pass-through of data_in/in_valid, gated to 0 during FLUSH.
- Stage update (en=1 only): stage0 valid <= accepted in_valid; stage0 data <= data_in lane if accepted, else 0. Stage i <= stage i-1.
- Accepted = en & in_valid & (state != FLUSH).
- Latency: a beat accepted at edge t appears on lane k after d_k advancing edges. Stalled cycles do not count toward latency.
- Mode lock: mode_q <= deskew only on an edge where state=IDLE and busy=0. Otherwise the deskew input is ignored.
- FSM states and transitions:
  - IDLE: accepted beat -> RUN. flush with busy=0 -> stay IDLE and pulse drained on the next cycle.
  - RUN: flush -> FLUSH, counter loads MAX_DEPTH. busy=0 after the edge and no accepted beat -> IDLE.
  - FLUSH: in_valid is ignored and zeros are injected. The counter decrements on each en=1 edge. At 0 -> IDLE and drained=1 for exactly one cycle; busy is guaranteed 0 at that point.
- Simultaneous flush and in_valid in RUN: that beat is accepted, then the flush starts. Counter = MAX_DEPTH guarantees the beat exits.
- Flush while already in FLUSH: ignored; the counter is not reloaded.
- flush with en=0: the request is still registered (FSM edge), but the counter holds until en=1.
- MAX_DEPTH=0 (single lane, BASE_DEPTH=0): pure pass-through. flush gives drained on the next cycle.

Decomposition:
- Shared include/package skew_delay_pkg:
  - FSM state encoding IDLE=2'd0, RUN=2'd1, FLUSH=2'd2.
  - Lane depth function depth_of(k, mode).
  - Counter width function clog2(MAX_DEPTH+1).
- One sub-module skew_lane: WIDTH, DEPTH params; clk, reset_n, en, in_valid, data_in, tap_sel.
  - It is a valid-tagged enabled shift register with a tap mux.
  - The top instantiates CHANNELS of them plus the FSM, mode register and flush counter (top ~150 lines, lane ~80 lines).

Test Plan:
1. Skew latency: WIDTH=16, CHANNELS=4, BASE_DEPTH=0, STEP=1, deskew=0. Single beat 0x1111/0x2222/0x3333/0x4444 at t0 -> lanes 0..3 show their values valid at t0+0/1/2/3. All other cycles show data 0 and valid 0.
2. Deskew and mode lock:
   - In IDLE, set deskew=1, then send the same beat -> lane 3 at +0, lane 0 at +3.
   - Toggle deskew to 0 while busy=1 -> delays unchanged until busy=0.
3. Stall: stream beats 1,2,3 with en low for 2 cycles mid-stream -> all outputs and out_valid freeze during the stall. Relative order and per-lane latency in advancing edges are unchanged.
4. Flush: in RUN, assert flush together with in_valid=1 (beat 0xAAAA) -> 0xAAAA emerges on every lane.
   - A further in_valid is ignored.
   - drained pulses once, exactly MAX_DEPTH=3 advancing edges after the flush edge; busy=0 and FSM=IDLE.
5. Idle flush and reset: flush in IDLE -> drained on the next cycle.
   - Mid-stream, assert reset_n=0 asynchronously between edges -> data_out, out_valid and busy go to 0 immediately.
   - After release, the first beat has normal latency.
6. Parameter sweep: CHANNELS=3, BASE_DEPTH=2, STEP=0 -> every lane has latency 2 and flush takes 2 edges. CHANNELS=1, BASE_DEPTH=0 -> combinational pass-through.

Source files
------------

// File: rtl/skew_delay_pkg.sv
// Shared types and elaboration-time helpers for the skewed multi-lane delay block.
// Lane depth and counter sizing live here so the top and the lanes agree on them.
package skew_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Bits needed to hold values 0..value-1, never less than one bit so that
    // zero-depth configurations still get a legal vector width.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Delay of lane k: ascending with lane index in skew mode, descending in deskew mode.
    function automatic int depth_of(
        input int   k,
        input logic mode,
        input int   channels,
        input int   base,
        input int   step
    );
        if (mode) begin
            return base + (channels - 1 - k) * step;
        end
        return base + k * step;
    endfunction

endpackage

// File: rtl/skew_delay_array_lane.sv
// One lane: a valid-tagged shift register that advances on en, with a tap mux
// selecting how many registered stages the lane output sits behind (0 = pass-through).
module skew_lane
    import skew_delay_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    localparam int TAP_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             stage_busy
);

    generate
        if (DEPTH == 0) begin : g_passthru
            logic unused_ok;
            assign unused_ok  = &{1'b0, clk, reset_n, en, tap_sel};
            assign out_valid  = in_valid;
            assign data_out   = in_valid ? data_in : '0;
            assign stage_busy = 1'b0;
        end else begin : g_shift
            logic [WIDTH-1:0] data_reg [DEPTH];
            logic [DEPTH-1:0] valid_reg;
            logic [WIDTH-1:0] sel_data;
            logic             sel_valid;

            // Empty slots carry zero data so the output never leaks stale values.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_reg[i] <= '0;
                    end
                end else if (en) begin
                    valid_reg[0] <= in_valid;
                    data_reg[0]  <= in_valid ? data_in : '0;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_reg[i] <= valid_reg[i-1];
                        data_reg[i]  <= data_reg[i-1];
                    end
                end
            end

            always_comb begin
                sel_valid = in_valid;
                sel_data  = data_in;
                for (int i = 1; i <= DEPTH; i++) begin
                    if (tap_sel == TAP_W'(i)) begin
                        sel_valid = valid_reg[i-1];
                        sel_data  = data_reg[i-1];
                    end
                end
            end

            assign out_valid  = sel_valid;
            assign data_out   = sel_valid ? sel_data : '0;
            assign stage_busy = |valid_reg;
        end
    endgenerate

endmodule

// File: rtl/skew_delay_array.sv
// Multi-lane skew/deskew delay for a systolic array edge, with stall, flush/drain
// handshake and a mode register that only follows deskew while the pipeline is empty.
module skew_delay_array
    import skew_delay_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int BASE_DEPTH = 0,
    parameter int STEP       = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      deskew,
    input  logic                      flush,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      busy,
    output logic                      drained
);

    localparam int MAX_DEPTH = BASE_DEPTH + (CHANNELS - 1) * STEP;
    localparam int TAP_W     = clog2(MAX_DEPTH + 1);
    localparam int CNT_W     = clog2(MAX_DEPTH + 1);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               drained_reg, drained_next;
    logic               mode_reg;
    logic               accepted;
    logic               flush_needed;
    logic [CHANNELS-1:0] lane_busy;

    // Gating with reset_n keeps zero-depth lanes dark while reset is held.
    assign accepted = reset_n & en & in_valid & (state_reg != FLUSH);
    assign busy     = |lane_busy;
    assign drained  = drained_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [TAP_W-1:0] tap_sel;
            assign tap_sel = TAP_W'(depth_of(gi, mode_reg, CHANNELS, BASE_DEPTH, STEP));

            skew_lane #(
                .WIDTH (WIDTH),
                .DEPTH (MAX_DEPTH)
            ) u_lane (
                .clk        (clk),
                .reset_n    (reset_n),
                .en         (en),
                .in_valid   (accepted),
                .data_in    (data_in[gi*WIDTH +: WIDTH]),
                .tap_sel    (tap_sel),
                .data_out   (data_out[gi*WIDTH +: WIDTH]),
                .out_valid  (out_valid[gi]),
                .stage_busy (lane_busy[gi])
            );
        end
    endgenerate

    // Switching tap positions with beats in flight would duplicate or drop them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg <= 1'b0;
        end else if (state_reg == IDLE && !busy) begin
            mode_reg <= deskew;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            drained_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            drained_reg <= drained_next;
        end
    end

    // A flush only needs the drain window if something is (or is about to be) in a stage.
    assign flush_needed = (busy | accepted) && (MAX_DEPTH != 0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        drained_next = 1'b0;
        case (state_reg)
            IDLE, RUN: begin
                if (flush) begin
                    if (flush_needed) begin
                        state_next = FLUSH;
                        cnt_next   = CNT_W'(MAX_DEPTH);
                    end else begin
                        state_next   = IDLE;
                        drained_next = 1'b1;
                    end
                end else if (accepted) begin
                    state_next = RUN;
                end else if (state_reg == RUN && en && !busy) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                if (en) begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        drained_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_skew_delay_array.sv
// Bench for skew_delay_array: beat-history model for the 4-lane skew config, plus
// directed literal checks for that config and for the 3-lane flat and 1-lane builds.
module tb_skew_delay_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, en;

    logic        a_in_valid, a_deskew, a_flush;
    logic [63:0] a_data_in, a_data_out;
    logic [3:0]  a_out_valid;
    logic        a_busy, a_drained;

    logic        b_in_valid, b_deskew, b_flush;
    logic [47:0] b_data_in, b_data_out;
    logic [2:0]  b_out_valid;
    logic        b_busy, b_drained;

    logic        c_in_valid, c_deskew, c_flush;
    logic [15:0] c_data_in, c_data_out;
    logic [0:0]  c_out_valid;
    logic        c_busy, c_drained;

    int n_vec = 0;
    int n_err = 0;

    skew_delay_array #(.WIDTH(16), .CHANNELS(4), .BASE_DEPTH(0), .STEP(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(a_in_valid), .data_in(a_data_in),
        .deskew(a_deskew), .flush(a_flush), .data_out(a_data_out), .out_valid(a_out_valid),
        .busy(a_busy), .drained(a_drained)
    );

    skew_delay_array #(.WIDTH(16), .CHANNELS(3), .BASE_DEPTH(2), .STEP(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(b_in_valid), .data_in(b_data_in),
        .deskew(b_deskew), .flush(b_flush), .data_out(b_data_out), .out_valid(b_out_valid),
        .busy(b_busy), .drained(b_drained)
    );

    skew_delay_array #(.WIDTH(16), .CHANNELS(1), .BASE_DEPTH(0), .STEP(1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(c_in_valid), .data_in(c_data_in),
        .deskew(c_deskew), .flush(c_flush), .data_out(c_data_out), .out_valid(c_out_valid),
        .busy(c_busy), .drained(c_drained)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of config A: history of beats accepted on the last three advancing edges
    // (index 0 = most recent), the remaining length of the flush window and the drained pulse.
    logic        m_hv [3];
    logic [63:0] m_hd [3];
    int          m_flush_left;
    logic        m_drained;
    logic        m_mode;
    logic        chk_on;

    always @(posedge clk or negedge reset_n) begin : model
        logic acc, inflight, drain_now;
        if (!reset_n) begin
            for (int j = 0; j < 3; j++) begin
                m_hv[j] = 1'b0;
                m_hd[j] = '0;
            end
            m_flush_left = 0;
            m_drained    = 1'b0;
        end else begin
            acc       = en && a_in_valid && (m_flush_left == 0);
            inflight  = m_hv[0] || m_hv[1] || m_hv[2];
            drain_now = 1'b0;
            if (m_flush_left > 0) begin
                if (en) begin
                    m_flush_left = m_flush_left - 1;
                    drain_now    = (m_flush_left == 0);
                end
            end else if (a_flush) begin
                if (acc || inflight) m_flush_left = 3;
                else                 drain_now = 1'b1;
            end
            if (en) begin
                m_hv[2] = m_hv[1];  m_hd[2] = m_hd[1];
                m_hv[1] = m_hv[0];  m_hd[1] = m_hd[0];
                m_hv[0] = acc;      m_hd[0] = acc ? a_data_in : 64'h0;
            end
            m_drained = drain_now;
        end
    end

    always @(negedge clk) begin : compare
        logic [63:0] exp_d;
        logic [3:0]  exp_v;
        int          d;
        if (chk_on) begin
            exp_d = '0;
            exp_v = '0;
            if (reset_n) begin
                for (int k = 0; k < 4; k++) begin
                    d = m_mode ? 3 - k : k;
                    if (d == 0) begin
                        if (en && a_in_valid && m_flush_left == 0) begin
                            exp_v[k]          = 1'b1;
                            exp_d[k*16 +: 16] = a_data_in[k*16 +: 16];
                        end
                    end else if (m_hv[d-1]) begin
                        exp_v[k]          = 1'b1;
                        exp_d[k*16 +: 16] = m_hd[d-1][k*16 +: 16];
                    end
                end
            end
            check("model data_out", a_data_out, exp_d);
            check("model out_valid", a_out_valid, exp_v);
            check("model busy", a_busy, reset_n & (m_hv[0] | m_hv[1] | m_hv[2]));
            check("model drained", a_drained, reset_n & m_drained);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        reset_n = 1'b0; en = 1'b1; chk_on = 1'b0; m_mode = 1'b0;
        a_in_valid = 0; a_deskew = 0; a_flush = 0; a_data_in = '0;
        b_in_valid = 0; b_deskew = 0; b_flush = 0; b_data_in = '0;
        c_in_valid = 0; c_deskew = 0; c_flush = 0; c_data_in = '0;

        #2;
        check("reset data_out", a_data_out, 64'h0);
        check("reset out_valid", a_out_valid, 4'b0000);
        check("reset busy", a_busy, 1'b0);
        check("reset drained", a_drained, 1'b0);
        #10 reset_n = 1'b1;
        chk_on = 1'b1;
        repeat (2) tick();

        // Skew latency
        $display("skew beat 4444_3333_2222_1111");
        a_data_in = 64'h4444_3333_2222_1111; a_in_valid = 1'b1; #1;
        check("skew c0 valid", a_out_valid, 4'b0001);
        check("skew c0 data", a_data_out, 64'h0000_0000_0000_1111);
        tick(); a_in_valid = 1'b0; a_data_in = '0; #1;
        check("skew c1 valid", a_out_valid, 4'b0010);
        check("skew c1 data", a_data_out, 64'h0000_0000_2222_0000);
        check("skew c1 busy", a_busy, 1'b1);
        tick(); #1;
        check("skew c2 valid", a_out_valid, 4'b0100);
        check("skew c2 data", a_data_out, 64'h0000_3333_0000_0000);
        tick(); #1;
        check("skew c3 valid", a_out_valid, 4'b1000);
        check("skew c3 data", a_data_out, 64'h4444_0000_0000_0000);
        tick(); #1;
        check("skew c4 valid", a_out_valid, 4'b0000);
        check("skew c4 busy", a_busy, 1'b0);
        repeat (2) tick();

        // Deskew, then a mode change request while busy must be ignored
        a_deskew = 1'b1;
        repeat (3) tick();
        m_mode = 1'b1;
        $display("deskew beat 4444_3333_2222_1111");
        a_data_in = 64'h4444_3333_2222_1111; a_in_valid = 1'b1; #1;
        check("deskew c0 valid", a_out_valid, 4'b1000);
        check("deskew c0 data", a_data_out, 64'h4444_0000_0000_0000);
        tick(); a_in_valid = 1'b0; a_data_in = '0; a_deskew = 1'b0; #1;
        check("deskew c1 valid", a_out_valid, 4'b0100);
        check("deskew c1 data", a_data_out, 64'h0000_3333_0000_0000);
        tick(); #1;
        check("lock c2 valid", a_out_valid, 4'b0010);
        check("lock c2 data", a_data_out, 64'h0000_0000_2222_0000);
        tick(); #1;
        check("lock c3 valid", a_out_valid, 4'b0001);
        check("lock c3 data", a_data_out, 64'h0000_0000_0000_1111);
        repeat (4) tick();
        m_mode = 1'b0;
        $display("skew beat 8888_7777_6666_5555");
        a_data_in = 64'h8888_7777_6666_5555; a_in_valid = 1'b1; #1;
        check("unlock c0 valid", a_out_valid, 4'b0001);
        tick(); a_in_valid = 1'b0; a_data_in = '0;
        repeat (4) tick();

        // Stall mid-stream with beat 3 held at the input
        $display("stream beat 1");
        a_data_in = 64'h0001_0001_0001_0001; a_in_valid = 1'b1;
        tick();
        $display("stream beat 2");
        a_data_in = 64'h0002_0002_0002_0002;
        tick();
        $display("stall with beat 3 pending");
        en = 1'b0; a_data_in = 64'h0003_0003_0003_0003; #1;
        check("stall1 valid", a_out_valid, 4'b0110);
        check("stall1 data", a_data_out, 64'h0000_0001_0002_0000);
        tick(); #1;
        check("stall2 valid", a_out_valid, 4'b0110);
        check("stall2 data", a_data_out, 64'h0000_0001_0002_0000);
        tick(); en = 1'b1; #1;
        check("resume valid", a_out_valid, 4'b0111);
        check("resume data", a_data_out, 64'h0000_0001_0002_0003);
        tick(); a_in_valid = 1'b0; a_data_in = '0; #1;
        check("post valid", a_out_valid, 4'b1110);
        check("post data", a_data_out, 64'h0001_0002_0003_0000);
        repeat (4) tick();

        // Flush in RUN together with a beat
        $display("beat 5555 then flush with AAAA");
        a_data_in = 64'h5555_5555_5555_5555; a_in_valid = 1'b1;
        tick();
        a_data_in = 64'hAAAA_AAAA_AAAA_AAAA; a_flush = 1'b1; #1;
        check("flush c0 valid", a_out_valid, 4'b0011);
        check("flush c0 data", a_data_out, 64'h0000_0000_5555_AAAA);
        tick(); a_flush = 1'b0; a_data_in = 64'hBBBB_BBBB_BBBB_BBBB; #1;
        check("flush c1 valid", a_out_valid, 4'b0110);
        check("flush c1 data", a_data_out, 64'h0000_5555_AAAA_0000);
        check("flush c1 drained", a_drained, 1'b0);
        tick(); #1;
        check("flush c2 data", a_data_out, 64'h5555_AAAA_0000_0000);
        check("flush c2 drained", a_drained, 1'b0);
        tick(); #1;
        check("flush c3 valid", a_out_valid, 4'b1000);
        check("flush c3 data", a_data_out, 64'hAAAA_0000_0000_0000);
        check("flush c3 drained", a_drained, 1'b0);
        tick(); a_in_valid = 1'b0; a_data_in = '0; #1;
        check("flush c4 drained", a_drained, 1'b1);
        check("flush c4 busy", a_busy, 1'b0);
        check("flush c4 valid", a_out_valid, 4'b0000);
        tick(); #1;
        check("flush c5 drained", a_drained, 1'b0);

        // Idle flush
        repeat (2) tick();
        $display("idle flush");
        a_flush = 1'b1;
        tick(); a_flush = 1'b0; #1;
        check("idle flush drained", a_drained, 1'b1);
        tick(); #1;
        check("idle flush drop", a_drained, 1'b0);

        // Asynchronous reset mid-stream
        $display("stream then async reset");
        a_data_in = 64'h1234_5678_9ABC_DEF0; a_in_valid = 1'b1;
        tick();
        a_data_in = 64'h0F0F_0F0F_0F0F_0F0F;
        tick(); #2;
        reset_n = 1'b0; #1;
        check("async rst data", a_data_out, 64'h0);
        check("async rst valid", a_out_valid, 4'b0000);
        check("async rst busy", a_busy, 1'b0);
        @(posedge clk); #4;
        reset_n = 1'b1; a_in_valid = 1'b0; a_data_in = '0;
        tick();
        $display("post-reset beat 4444_3333_2222_1111");
        a_data_in = 64'h4444_3333_2222_1111; a_in_valid = 1'b1;
        tick(); a_in_valid = 1'b0; a_data_in = '0;
        tick(); tick(); #1;
        check("post rst c3 valid", a_out_valid, 4'b1000);
        check("post rst c3 data", a_data_out, 64'h4444_0000_0000_0000);
        repeat (3) tick();

        // Flat config: three lanes, depth 2 each
        $display("flat beat 0CCC_0BBB_0AAA");
        b_data_in = 48'h0CCC_0BBB_0AAA; b_in_valid = 1'b1; #1;
        check("flat c0 valid", b_out_valid, 3'b000);
        tick(); b_in_valid = 1'b0; b_data_in = '0; b_flush = 1'b1; #1;
        check("flat c1 valid", b_out_valid, 3'b000);
        check("flat c1 busy", b_busy, 1'b1);
        tick(); b_flush = 1'b0; #1;
        check("flat c2 valid", b_out_valid, 3'b111);
        check("flat c2 data", b_data_out, 48'h0CCC_0BBB_0AAA);
        check("flat c2 drained", b_drained, 1'b0);
        tick(); #1;
        check("flat c3 valid", b_out_valid, 3'b000);
        check("flat c3 busy", b_busy, 1'b0);
        check("flat c3 drained", b_drained, 1'b0);
        tick(); #1;
        check("flat c4 drained", b_drained, 1'b1);
        tick(); #1;
        check("flat c5 drained", b_drained, 1'b0);

        // Single lane: pure pass-through
        $display("single lane beat 1234");
        c_data_in = 16'h1234; c_in_valid = 1'b1; #1;
        check("single c0 valid", c_out_valid, 1'b1);
        check("single c0 data", c_data_out, 16'h1234);
        tick(); c_in_valid = 1'b0; c_data_in = '0; c_flush = 1'b1; #1;
        check("single c1 valid", c_out_valid, 1'b0);
        check("single c1 data", c_data_out, 16'h0);
        tick(); c_flush = 1'b0; #1;
        check("single drained", c_drained, 1'b1);
        tick(); #1;
        check("single drained drop", c_drained, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
